// File: rtl/mux_n_reg.sv
// mux_n_reg: registered N-way word selector with valid/ready on both sides
//   clk, rst_n            clock, async active-low reset
//   in_data/in_sel        NUM_IN concatenated words and the index to forward
//   in_valid/in_ready     upstream handshake (in_ready is registered)
//   out_data/out_err      selected word; err marks an out-of-range select
//   out_valid/out_ready   downstream handshake
//   beat_count            output transfers since reset, wrapping
module mux_n_reg #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        beat_count
);
  logic [WIDTH-1:0] sel_data, skid_data;
  logic             sel_err, skid_err, skid_full;
  logic             xfer, drain, load_main, skid_nxt;
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_IN; k++)
      if (in_sel == SEL_W'(k)) sel_data = in_data[k*WIDTH +: WIDTH];
  end
  assign sel_err   = 32'(in_sel) >= NUM_IN;
  assign xfer      = in_valid && in_ready;
  assign drain     = out_valid && out_ready;
  assign load_main = !out_valid || drain;
  // When main refills from skid, a concurrent input beat takes skid's place.
  assign skid_nxt  = load_main ? skid_full && xfer : skid_full || xfer;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_err    <= 1'b0;
      skid_full  <= 1'b0;
      skid_data  <= '0;
      skid_err   <= 1'b0;
      in_ready   <= 1'b1;
      beat_count <= '0;
    end else begin
      if (load_main) begin
        out_valid <= skid_full || xfer;
        if (skid_full || xfer) begin
          out_data <= skid_full ? skid_data : sel_data;
          out_err  <= skid_full ? skid_err : sel_err;
        end
      end
      if (xfer && (!load_main || skid_full)) begin
        skid_data <= sel_data;
        skid_err  <= sel_err;
      end
      skid_full  <= skid_nxt;
      in_ready   <= !skid_nxt;
      beat_count <= beat_count + CNT_W'(drain);
    end
endmodule

// File: tb/tb_mux_n_reg.sv
// tb_mux_n_reg: self-checking bench for mux_n_reg (4-input/4-bit-count and 3-input/16-bit-count copies)
module tb_mux_n_reg;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] in_data = '0;
  logic [1:0]   in_sel = '0;
  logic         in_valid = 1'b0, out_ready = 1'b0;
  logic         ir_a, oe_a, ov_a, ir_b, oe_b, ov_b;
  logic [31:0]  od_a, od_b;
  logic [3:0]   bc_a;
  logic [15:0]  bc_b;
  always #5 clk = ~clk;
  mux_n_reg #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(ir_a), .out_data(od_a), .out_err(oe_a), .out_valid(ov_a),
    .out_ready(out_ready), .beat_count(bc_a));
  mux_n_reg #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[95:0]), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(ir_b), .out_data(od_b), .out_err(oe_b), .out_valid(ov_b),
    .out_ready(out_ready), .beat_count(bc_b));
  typedef struct {logic [31:0] da; logic ea; logic [31:0] db; logic eb;} beat_t;
  typedef struct {
    bit v; logic [1:0] sel; bit rdy;
    bit ev; logic [31:0] eda; bit eea; logic [31:0] edb; bit eeb; bit eir; int ecnt;
  } vec_t;
  beat_t       q[$];
  int unsigned delivered = 0;
  int          errors = 0, checks = 0;
  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  // Reference: a FIFO holding at most two beats; ready means fewer than two held.
  task automatic model_check();
    chk("model out_valid a", 64'(ov_a), 64'(q.size() > 0));
    chk("model out_valid b", 64'(ov_b), 64'(q.size() > 0));
    chk("model in_ready a", 64'(ir_a), 64'(q.size() < 2));
    chk("model in_ready b", 64'(ir_b), 64'(q.size() < 2));
    chk("model count a", 64'(bc_a), 64'(delivered % 16));
    chk("model count b", 64'(bc_b), 64'(delivered % 65536));
    if (q.size() > 0) begin
      chk("model data a", 64'(od_a), 64'(q[0].da));
      chk("model err a", 64'(oe_a), 64'(q[0].ea));
      chk("model data b", 64'(od_b), 64'(q[0].db));
      chk("model err b", 64'(oe_b), 64'(q[0].eb));
    end
  endtask
  task automatic tick();
    bit xi, xo;
    beat_t b;
    int s;
    s  = int'(in_sel);
    xi = in_valid && q.size() < 2;
    xo = q.size() > 0 && out_ready;
    b.da = in_data[s*32 +: 32];
    b.ea = 1'b0;
    b.db = s < 3 ? in_data[s*32 +: 32] : 32'h0;
    b.eb = s >= 3;
    @(posedge clk);
    if (xo) begin
      void'(q.pop_front());
      delivered++;
    end
    if (xi) q.push_back(b);
    @(negedge clk);
    model_check();
  endtask
  task automatic randomize_inputs();
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    in_sel   = 2'($urandom);
    in_valid = 1'($urandom);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      out_ready = 1'($urandom);
      @(negedge clk);
    end
    chk("reset out_valid a", 64'(ov_a), 64'(0));
    chk("reset out_valid b", 64'(ov_b), 64'(0));
    chk("reset out_data a", 64'(od_a), 64'(0));
    chk("reset out_data b", 64'(od_b), 64'(0));
    chk("reset out_err a", 64'(oe_a), 64'(0));
    chk("reset out_err b", 64'(oe_b), 64'(0));
    chk("reset count a", 64'(bc_a), 64'(0));
    chk("reset count b", 64'(bc_b), 64'(0));
    chk("reset in_ready a", 64'(ir_a), 64'(1));
    chk("reset in_ready b", 64'(ir_b), 64'(1));
    q.delete();
    delivered = 0;
    in_valid = 1'b0;
    rst_n = 1'b1;
  endtask
  vec_t tv[13];
  initial begin
    tv[0]  = '{1, 2'd3, 1, 1, 32'h44444444, 0, 32'h00000000, 1, 1, 0};
    tv[1]  = '{1, 2'd0, 1, 1, 32'h11111111, 0, 32'h11111111, 0, 1, 1};
    tv[2]  = '{1, 2'd2, 1, 1, 32'h33333333, 0, 32'h33333333, 0, 1, 2};
    tv[3]  = '{1, 2'd1, 1, 1, 32'h22222222, 0, 32'h22222222, 0, 1, 3};
    tv[4]  = '{0, 2'd0, 1, 0, 32'h0,        0, 32'h0,        0, 1, 4};
    tv[5]  = '{1, 2'd1, 0, 1, 32'h22222222, 0, 32'h22222222, 0, 1, 4};
    tv[6]  = '{1, 2'd2, 0, 1, 32'h22222222, 0, 32'h22222222, 0, 0, 4};
    tv[7]  = '{1, 2'd0, 0, 1, 32'h22222222, 0, 32'h22222222, 0, 0, 4};
    tv[8]  = '{0, 2'd0, 1, 1, 32'h33333333, 0, 32'h33333333, 0, 1, 5};
    tv[9]  = '{0, 2'd0, 1, 0, 32'h0,        0, 32'h0,        0, 1, 6};
    tv[10] = '{1, 2'd3, 1, 1, 32'h44444444, 0, 32'h00000000, 1, 1, 6};
    tv[11] = '{1, 2'd0, 1, 1, 32'h11111111, 0, 32'h11111111, 0, 1, 7};
    tv[12] = '{0, 2'd0, 1, 0, 32'h0,        0, 32'h0,        0, 1, 8};
    do_reset();
    in_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    foreach (tv[i]) begin
      in_valid  = tv[i].v;
      in_sel    = tv[i].sel;
      out_ready = tv[i].rdy;
      tick();
      chk($sformatf("vec%0d out_valid", i), 64'(ov_a), 64'(tv[i].ev));
      chk($sformatf("vec%0d in_ready", i), 64'(ir_a), 64'(tv[i].eir));
      chk($sformatf("vec%0d count", i), 64'(bc_b), 64'(tv[i].ecnt));
      if (tv[i].ev) begin
        chk($sformatf("vec%0d data a", i), 64'(od_a), 64'(tv[i].eda));
        chk($sformatf("vec%0d err a", i), 64'(oe_a), 64'(tv[i].eea));
        chk($sformatf("vec%0d data b", i), 64'(od_b), 64'(tv[i].edb));
        chk($sformatf("vec%0d err b", i), 64'(oe_b), 64'(tv[i].eeb));
      end
    end
    // Counter wrap: 17 transfers on the 4-bit counter land on 1.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      randomize_inputs();
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("wrap count a", 64'(bc_a), 64'(1));
    chk("wrap count b", 64'(bc_b), 64'(17));
    // Random traffic with varying back-pressure.
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 8) < ((i / 500) % 4 + 3);
      tick();
    end
    // Reset mid-stream: two beats held, then an async reset between edges.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      randomize_inputs();
      in_valid = 1'b1;
      tick();
    end
    chk("held in_ready", 64'(ir_a), 64'(0));
    #2 rst_n = 1'b0;
    #1;
    chk("async out_valid a", 64'(ov_a), 64'(0));
    chk("async out_valid b", 64'(ov_b), 64'(0));
    chk("async in_ready a", 64'(ir_a), 64'(1));
    chk("async count b", 64'(bc_b), 64'(0));
    q.delete();
    delivered = 0;
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    randomize_inputs();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
